// File: rtl/maze_wall_sensor.sv
// maze_wall_sensor: scans eight tile-map points just outside the ball's
// bounding box and publishes four wall-adjacency flags atomically.
//
// state | meaning
// IDLE  | waiting for sampleTick, flags hold the last completed scan
// PROBE | issuing one tile read per cycle for probes k0..k7
// DRAIN | waiting for the final read to return, then publishing flags
module maze_wall_sensor #(
  parameter int BALL_SIZE  = 4,
  parameter int TILE_SHIFT = 3,
  localparam int MAP_BITS  = 8 - TILE_SHIFT
) (
  input  logic                  clk108MHz,
  input  logic                  resetPressedN,
  input  logic                  sampleTick,
  input  logic [7:0]            ballColumn,
  input  logic [7:0]            ballRow,
  output logic                  memRd,
  output logic [2*MAP_BITS-1:0] memAddr,
  input  logic                  memData,
  output logic                  wallAboveball,
  output logic                  wallBelowball,
  output logic                  wallLeftOfball,
  output logic                  wallRightOfball,
  output logic                  flagsValid,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, PROBE, DRAIN} state_t;

  // Ten-bit unsigned arithmetic: any result outside 0..255 shows up in bits [9:8].
  localparam logic [9:0] SZ = 10'(BALL_SIZE);

  state_t                state_q, state_d;
  logic [2:0]            k_q, k_d;
  logic [7:0]            col_q, col_d;
  logic [7:0]            row_q, row_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [2*MAP_BITS-1:0] mem_addr_q, mem_addr_d;
  // Direction / out-of-range tag of the read presented this cycle.
  logic [1:0]            probe_dir_q, probe_dir_d;
  logic                  probe_oor_q, probe_oor_d;
  // Same tag one cycle later, aligned with memData.
  logic                  cap_vld_q, cap_vld_d;
  logic [1:0]            cap_dir_q, cap_dir_d;
  logic                  cap_oor_q, cap_oor_d;
  // Bit order for shadow/flags: 0 above, 1 below, 2 left, 3 right.
  logic [3:0]            shadow_q, shadow_d;
  logic [3:0]            flags_q, flags_d;
  logic                  flags_valid_q, flags_valid_d;
  logic                  busy_q, busy_d;

  logic [2:0]            probe_k;
  logic [7:0]            probe_c, probe_r;
  logic [9:0]            base_x, base_y, probe_x, probe_y;
  logic                  probe_oor;
  logic [2*MAP_BITS-1:0] probe_addr;

  // Coordinates and tile address of the probe to be issued at the next edge.
  // At scan start the live ball position is used since C/R latch on that edge.
  always_comb begin
    probe_k = (state_q == IDLE) ? 3'd0 : k_q + 3'd1;
    probe_c = (state_q == IDLE) ? ballColumn : col_q;
    probe_r = (state_q == IDLE) ? ballRow : row_q;
    base_x  = {2'b00, probe_c};
    base_y  = {2'b00, probe_r};
    probe_x = base_x;
    probe_y = base_y;
    case (probe_k)
      3'd0: probe_y = base_y - 10'd1;
      3'd1: begin
        probe_x = base_x + SZ - 10'd1;
        probe_y = base_y - 10'd1;
      end
      3'd2: probe_y = base_y + SZ;
      3'd3: begin
        probe_x = base_x + SZ - 10'd1;
        probe_y = base_y + SZ;
      end
      3'd4: probe_x = base_x - 10'd1;
      3'd5: begin
        probe_x = base_x - 10'd1;
        probe_y = base_y + SZ - 10'd1;
      end
      3'd6: probe_x = base_x + SZ;
      default: begin
        probe_x = base_x + SZ;
        probe_y = base_y + SZ - 10'd1;
      end
    endcase
    probe_oor  = (probe_x[9:8] != 2'b00) || (probe_y[9:8] != 2'b00);
    probe_addr = probe_oor ? '0
               : {MAP_BITS'(probe_y[7:0] >> TILE_SHIFT),
                  MAP_BITS'(probe_x[7:0] >> TILE_SHIFT)};
  end

  // Next-state logic: scan sequencing, result accumulation and flag publish.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    col_d         = col_q;
    row_d         = row_q;
    mem_rd_d      = 1'b0;
    mem_addr_d    = '0;
    probe_dir_d   = probe_dir_q;
    probe_oor_d   = 1'b0;
    cap_vld_d     = mem_rd_q;
    cap_dir_d     = probe_dir_q;
    cap_oor_d     = probe_oor_q;
    shadow_d      = shadow_q;
    flags_d       = flags_q;
    flags_valid_d = 1'b0;

    // An out-of-range probe is a wall whatever the memory returns.
    if (cap_vld_q && (cap_oor_q || memData)) begin
      shadow_d[cap_dir_q] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (sampleTick) begin
          state_d     = PROBE;
          col_d       = ballColumn;
          row_d       = ballRow;
          k_d         = 3'd0;
          shadow_d    = '0;
          mem_rd_d    = 1'b1;
          mem_addr_d  = probe_addr;
          probe_dir_d = probe_k[2:1];
          probe_oor_d = probe_oor;
        end
      end
      PROBE: begin
        if (k_q == 3'd7) begin
          state_d = DRAIN;
        end else begin
          k_d         = k_q + 3'd1;
          mem_rd_d    = 1'b1;
          mem_addr_d  = probe_addr;
          probe_dir_d = probe_k[2:1];
          probe_oor_d = probe_oor;
        end
      end
      DRAIN: begin
        state_d       = IDLE;
        flags_d       = shadow_d;
        flags_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset leaves the ball frozen by wall flags.
  always_ff @(posedge clk108MHz or negedge resetPressedN) begin
    if (!resetPressedN) begin
      state_q       <= IDLE;
      k_q           <= 3'd0;
      col_q         <= 8'd0;
      row_q         <= 8'd0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      probe_dir_q   <= 2'd0;
      probe_oor_q   <= 1'b0;
      cap_vld_q     <= 1'b0;
      cap_dir_q     <= 2'd0;
      cap_oor_q     <= 1'b0;
      shadow_q      <= 4'h0;
      flags_q       <= 4'hF;
      flags_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      col_q         <= col_d;
      row_q         <= row_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      probe_dir_q   <= probe_dir_d;
      probe_oor_q   <= probe_oor_d;
      cap_vld_q     <= cap_vld_d;
      cap_dir_q     <= cap_dir_d;
      cap_oor_q     <= cap_oor_d;
      shadow_q      <= shadow_d;
      flags_q       <= flags_d;
      flags_valid_q <= flags_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign memRd           = mem_rd_q;
  assign memAddr         = mem_addr_q;
  assign wallAboveball   = flags_q[0];
  assign wallBelowball   = flags_q[1];
  assign wallLeftOfball  = flags_q[2];
  assign wallRightOfball = flags_q[3];
  assign flagsValid      = flags_valid_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_maze_wall_sensor.sv
// Directed bench for maze_wall_sensor: a table of ball positions and wall
// tiles with hand-computed flags, plus control sequences (ignored ticks,
// back-to-back scans, reset mid-scan).
module tb_maze_wall_sensor;

  logic       clk108MHz = 1'b0;
  logic       resetPressedN;
  logic       sampleTick;
  logic [7:0] ballColumn, ballRow;
  logic       memRd;
  logic [9:0] memAddr;
  logic       memData;
  logic       wallAboveball, wallBelowball, wallLeftOfball, wallRightOfball;
  logic       flagsValid, busy;

  maze_wall_sensor #(.BALL_SIZE(4), .TILE_SHIFT(3)) dut (
    .clk108MHz       (clk108MHz),
    .resetPressedN   (resetPressedN),
    .sampleTick      (sampleTick),
    .ballColumn      (ballColumn),
    .ballRow         (ballRow),
    .memRd           (memRd),
    .memAddr         (memAddr),
    .memData         (memData),
    .wallAboveball   (wallAboveball),
    .wallBelowball   (wallBelowball),
    .wallLeftOfball  (wallLeftOfball),
    .wallRightOfball (wallRightOfball),
    .flagsValid      (flagsValid),
    .busy            (busy)
  );

  always #5 clk108MHz = ~clk108MHz;

  // Tile memory model: one-cycle synchronous read.
  logic tmap [0:1023];
  always @(posedge clk108MHz) memData <= memRd ? tmap[memAddr] : 1'b0;

  logic [3:0] flags_now;
  assign flags_now = {wallAboveball, wallBelowball, wallLeftOfball, wallRightOfball};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Per-cycle log of one run; bit i refers to the state just after edge E(i).
  logic [31:0] rd_bits, fv_bits, busy_bits;
  logic [9:0]  addr_log [0:31];
  logic [3:0]  flags_at_fv;

  task automatic run(input logic [7:0] c, input logic [7:0] r,
                     input logic [31:0] tick_mask, input int n);
    rd_bits = '0; fv_bits = '0; busy_bits = '0;
    flags_at_fv = 4'h5;
    for (int i = 0; i < n; i++) begin
      @(negedge clk108MHz);
      if (i == 0)  begin ballColumn = c;  ballRow = r;  end
      if (i == 2)  begin ballColumn = ~c; ballRow = ~r; end
      if (i == 10) begin ballColumn = c;  ballRow = r;  end
      sampleTick = tick_mask[i];
      @(posedge clk108MHz);
      #1;
      rd_bits[i]   = memRd;
      fv_bits[i]   = flagsValid;
      busy_bits[i] = busy;
      addr_log[i]  = memAddr;
      if (flagsValid) flags_at_fv = flags_now;
    end
    @(negedge clk108MHz);
    sampleTick = 1'b0;
  endtask

  typedef struct {
    logic [7:0] col;
    logic [7:0] row;
    logic       a_en;
    logic [9:0] a;
    logic       b_en;
    logic [9:0] b;
    logic [3:0] exp;      // {above, below, left, right}
    int         addr_idx; // row of exp_addr to check, -1 for none
  } vec_t;

  vec_t       vecs [0:7];
  logic [9:0] exp_addr [0:1][0:7];

  initial begin
    // {row,col} packed as row*32+col: {12,12}=396 {12,13}=397 {13,12}=428 {13,13}=429
    vecs[0] = '{8'd100, 8'd100, 1'b0, 10'd0,   1'b0, 10'd0,   4'b0000,  0};
    vecs[1] = '{8'd100, 8'd100, 1'b1, 10'd429, 1'b0, 10'd0,   4'b0000, -1};
    vecs[2] = '{8'd100, 8'd100, 1'b1, 10'd397, 1'b0, 10'd0,   4'b0001, -1};
    vecs[3] = '{8'd100, 8'd100, 1'b1, 10'd397, 1'b1, 10'd428, 4'b0101, -1};
    vecs[4] = '{8'd0,   8'd0,   1'b0, 10'd0,   1'b0, 10'd0,   4'b1010, -1};
    vecs[5] = '{8'd252, 8'd252, 1'b0, 10'd0,   1'b0, 10'd0,   4'b0101,  1};
    vecs[6] = '{8'd100, 8'd100, 1'b1, 10'd396, 1'b0, 10'd0,   4'b1010, -1};
    vecs[7] = '{8'd200, 8'd60,  1'b1, 10'd249, 1'b0, 10'd0,   4'b1001, -1};
    exp_addr[0] = '{10'd396, 10'd396, 10'd428, 10'd428, 10'd396, 10'd396, 10'd397, 10'd397};
    exp_addr[1] = '{10'd1023, 10'd1023, 10'd0, 10'd0, 10'd1023, 10'd1023, 10'd0, 10'd0};

    for (int t = 0; t < 1024; t++) tmap[t] = 1'b0;
    resetPressedN = 1'b0;
    sampleTick    = 1'b0;
    ballColumn    = 8'd0;
    ballRow       = 8'd0;
    #12;
    chk("reset_flags", 32'(flags_now), 32'hF);
    chk("reset_fv",    32'(flagsValid), 32'h0);
    chk("reset_busy",  32'(busy), 32'h0);
    chk("reset_memrd", 32'(memRd), 32'h0);
    chk("reset_addr",  32'(memAddr), 32'h0);
    @(negedge clk108MHz);
    resetPressedN = 1'b1;

    for (int v = 0; v < 8; v++) begin
      for (int t = 0; t < 1024; t++) tmap[t] = 1'b0;
      if (vecs[v].a_en) tmap[vecs[v].a] = 1'b1;
      if (vecs[v].b_en) tmap[vecs[v].b] = 1'b1;
      run(vecs[v].col, vecs[v].row, 32'h1, 12);
      chk($sformatf("v%0d_flags_at_valid", v), 32'(flags_at_fv), 32'(vecs[v].exp));
      chk($sformatf("v%0d_flags_held", v), 32'(flags_now), 32'(vecs[v].exp));
      chk($sformatf("v%0d_memrd_cycles", v), rd_bits, 32'h0FF);
      chk($sformatf("v%0d_valid_cycle", v), fv_bits, 32'h200);
      chk($sformatf("v%0d_busy_cycles", v), busy_bits, 32'h1FF);
      if (vecs[v].addr_idx >= 0) begin
        for (int k = 0; k < 8; k++)
          chk($sformatf("v%0d_addr_k%0d", v, k), 32'(addr_log[k]),
              32'(exp_addr[vecs[v].addr_idx][k]));
      end
    end

    // Ticks at E3 and E9 ignored, tick at E10 starts a second scan.
    for (int t = 0; t < 1024; t++) tmap[t] = 1'b0;
    run(8'd100, 8'd100, 32'h0000_0609, 22);
    chk("ctl_memrd_pattern", rd_bits, 32'h0003_FCFF);
    chk("ctl_valid_pattern", fv_bits, 32'h0008_0200);
    chk("ctl_busy_pattern",  busy_bits, 32'h0007_FDFF);
    chk("ctl_flags", 32'(flags_now), 32'h0);

    // Reset at E5 aborts the scan.
    run(8'd100, 8'd100, 32'h1, 5);
    chk("rst_pre_memrd", rd_bits, 32'h1F);
    @(posedge clk108MHz);
    #1;
    resetPressedN = 1'b0;
    #1;
    chk("rst_memrd", 32'(memRd), 32'h0);
    chk("rst_flags", 32'(flags_now), 32'hF);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_fv",    32'(flagsValid), 32'h0);
    @(negedge clk108MHz);
    resetPressedN = 1'b1;
    run(8'd100, 8'd100, 32'h0, 12);
    chk("post_rst_memrd", rd_bits, 32'h0);
    chk("post_rst_valid", fv_bits, 32'h0);
    chk("post_rst_flags", 32'(flags_now), 32'hF);
    run(8'd100, 8'd100, 32'h1, 12);
    chk("rescan_valid", fv_bits, 32'h200);
    chk("rescan_flags", 32'(flags_now), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
